// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM burst controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_WAIT   = 3'd1,
    S_W_SETUP  = 3'd2,
    S_W_PULSE  = 3'd3,
    S_W_HOLD   = 3'd4,
    S_R_ACCESS = 3'd5,
    S_TURN     = 3'd6
  } state_e;

  localparam logic STROBE_IDLE = 1'b1;
  localparam logic UART_IDLE   = 1'b1;
  localparam int   TMR_W       = 8;

  function automatic int len_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter; done_o marks the last cycle of a loaded interval.
module sram_wait_timer
  import sram_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sram_burst_ctrl.sv
// Single/burst read-write controller for one asynchronous SRAM bank with
// programmable setup, write-pulse, hold and read-access wait states.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  parameter int READ_CYC  = 2,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = len_w(MAX_BURST)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              Ram_EN,
  output logic              Ram_OE,
  output logic              Ram_WE,
  output logic [ADDR_W-1:0] Ram_address,
  inout  wire  [DATA_W-1:0] Ram_data,
  output logic              rdn,
  output logic              wrn
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    beats_q;
  logic [DATA_W-1:0]   data_q, rdata_q;
  logic                rdata_valid_q, last_rd_q;
  logic                en_q, oe_q, we_q, drive_q, wready_q, busy_q, cready_q;
  logic                en_d, oe_d, we_d, drive_d, wready_d, busy_d, cready_d;
  logic                tmr_load_s, tmr_done_s, last_beat_s;
  logic [TMR_W-1:0]    tmr_val_s;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == {LEN_W{1'b0}}) begin
      clamp_len = LEN_W'(1);
    end else if (len > LEN_W'(MAX_BURST)) begin
      clamp_len = LEN_W'(MAX_BURST);
    end else begin
      clamp_len = len;
    end
  endfunction

  assign last_beat_s = (beats_q == LEN_W'(1));

  // Every timed state reloads on entry; R_ACCESS also reloads per beat.
  assign tmr_load_s = (state_d != state_q) || tmr_done_s;

  // Wait-state length for the state about to be entered.
  always_comb begin
    case (state_d)
      S_W_SETUP:  tmr_val_s = TMR_W'(SETUP_CYC);
      S_W_PULSE:  tmr_val_s = TMR_W'(WE_CYC);
      S_W_HOLD:   tmr_val_s = TMR_W'(HOLD_CYC);
      S_R_ACCESS: tmr_val_s = TMR_W'(READ_CYC);
      default:    tmr_val_s = {TMR_W{1'b0}};
    endcase
  end

  sram_wait_timer #(.W(TMR_W)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .done_o     (tmr_done_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_we) begin
            state_d = last_rd_q ? S_TURN : S_W_WAIT;
          end else begin
            state_d = S_R_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN:    state_d = S_W_WAIT;
      S_W_WAIT:  state_d = wdata_valid ? S_W_SETUP : S_W_WAIT;
      S_W_SETUP: state_d = tmr_done_s ? S_W_PULSE : S_W_SETUP;
      S_W_PULSE: state_d = tmr_done_s ? S_W_HOLD : S_W_PULSE;
      S_W_HOLD: begin
        if (tmr_done_s) begin
          state_d = last_beat_s ? S_IDLE : S_W_WAIT;
        end else begin
          state_d = S_W_HOLD;
        end
      end
      S_R_ACCESS: begin
        if (tmr_done_s && last_beat_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_R_ACCESS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    en_d     = (state_d == S_IDLE) ? STROBE_IDLE : ~STROBE_IDLE;
    oe_d     = (state_d == S_R_ACCESS) ? ~STROBE_IDLE : STROBE_IDLE;
    we_d     = (state_d == S_W_PULSE) ? ~STROBE_IDLE : STROBE_IDLE;
    drive_d  = (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
    wready_d = (state_d == S_W_WAIT);
    busy_d   = (state_d != S_IDLE);
    cready_d = (state_d == S_IDLE);
  end

  // Registered strobes and handshake outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q     <= STROBE_IDLE;
      oe_q     <= STROBE_IDLE;
      we_q     <= STROBE_IDLE;
      drive_q  <= 1'b0;
      wready_q <= 1'b0;
      busy_q   <= 1'b0;
      cready_q <= 1'b1;
    end else begin
      en_q     <= en_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      drive_q  <= drive_d;
      wready_q <= wready_d;
      busy_q   <= busy_d;
      cready_q <= cready_d;
    end
  end

  // Address, beat count, write data and read capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q        <= {ADDR_W{1'b0}};
      beats_q       <= {LEN_W{1'b0}};
      data_q        <= {DATA_W{1'b0}};
      rdata_q       <= {DATA_W{1'b0}};
      rdata_valid_q <= 1'b0;
      last_rd_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            beats_q   <= clamp_len(cmd_len);
            last_rd_q <= ~cmd_we;
          end
        end
        S_W_WAIT: begin
          if (wdata_valid) begin
            data_q <= wdata;
          end
        end
        S_W_HOLD: begin
          if (tmr_done_s && !last_beat_s) begin
            addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            beats_q <= beats_q - LEN_W'(1);
          end
        end
        S_R_ACCESS: begin
          if (tmr_done_s) begin
            rdata_q       <= Ram_data;
            rdata_valid_q <= 1'b1;
            if (!last_beat_s) begin
              addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              beats_q <= beats_q - LEN_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Ram_data    = drive_q ? data_q : {DATA_W{1'bz}};
  assign Ram_address = addr_q;
  assign Ram_EN      = en_q;
  assign Ram_OE      = oe_q;
  assign Ram_WE      = we_q;
  assign cmd_ready   = cready_q;
  assign wdata_ready = wready_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdn         = UART_IDLE;
  assign wrn         = UART_IDLE;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed plus randomized bench for sram_burst_ctrl with an SRAM pin model
// and an address-to-data reference memory.
module tb_sram_burst_ctrl;

  localparam int SETUP = 1;
  localparam int WEC   = 2;
  localparam int HOLD  = 1;
  localparam int RDC   = 2;
  localparam int MAXB  = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [17:0] cmd_addr = 18'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [15:0] wdata = 16'd0;
  logic        wdata_valid = 1'b0;
  logic        cmd_ready, wdata_ready, rdata_valid, busy;
  logic        Ram_EN, Ram_OE, Ram_WE, rdn, wrn;
  logic [15:0] rdata;
  logic [17:0] Ram_address;
  wire  [15:0] Ram_data;

  int n_cmp = 0;
  int n_err = 0;
  int we_pulses = 0, rd_beats = 0, oe_low = 0, we_run = 0;
  logic        we_prev = 1'b1, prev_rd = 1'b0;
  logic [17:0] prev_addr = 18'd0, pulse_addr = 18'd0;
  logic [15:0] prev_data = 16'd0, pulse_data = 16'd0, dev_out = 16'd0;
  logic [15:0] dev_wr [logic [17:0]];
  logic [15:0] ref_wr [logic [17:0]];
  logic [15:0] exp_rd [$];

  always #5 CLK = ~CLK;

  sram_burst_ctrl #(
    .ADDR_W(18), .DATA_W(16), .SETUP_CYC(SETUP), .WE_CYC(WEC),
    .HOLD_CYC(HOLD), .READ_CYC(RDC), .MAX_BURST(MAXB)
  ) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .Ram_EN(Ram_EN), .Ram_OE(Ram_OE),
    .Ram_WE(Ram_WE), .Ram_address(Ram_address), .Ram_data(Ram_data),
    .rdn(rdn), .wrn(wrn)
  );

  // SRAM device: drives the bus only while selected and output-enabled.
  assign Ram_data = (!Ram_EN && !Ram_OE && Ram_WE) ? dev_out : 16'hzzzz;

  function automatic logic [15:0] init_pat(input logic [17:0] a);
    return (a[15:0] ^ 16'h5A5A) + {a[17:16], 14'd0};
  endfunction

  function automatic logic [15:0] dev_rd(input logic [17:0] a);
    if (dev_wr.exists(a)) return dev_wr[a];
    return init_pat(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return init_pat(a);
  endfunction

  function automatic int eff_len(input int len);
    if (len == 0) return 1;
    if (len > MAXB) return MAXB;
    return len;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pin monitor: write-strobe timing, device write commit, read-beat scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      we_prev = 1'b1;
      we_run  = 0;
    end else begin
      if (!Ram_WE) begin
        check("oe_high_while_we_low", 32'(Ram_OE), 32'd1);
        if (we_prev) begin
          check("setup_addr", 32'(Ram_address), 32'(prev_addr));
          check("setup_data", 32'(Ram_data), 32'(prev_data));
          pulse_addr = Ram_address;
          pulse_data = Ram_data;
        end else begin
          check("pulse_addr", 32'(Ram_address), 32'(pulse_addr));
        end
        we_run++;
      end else if (!we_prev) begin
        check("we_width", 32'(we_run), 32'(WEC));
        check("hold_addr", 32'(Ram_address), 32'(pulse_addr));
        check("hold_data", 32'(Ram_data), 32'(pulse_data));
        if (!Ram_EN) dev_wr[Ram_address] = Ram_data;
        we_pulses++;
        we_run = 0;
      end
      if (!Ram_OE) begin
        oe_low++;
        check("en_low_with_oe", 32'(Ram_EN), 32'd0);
      end
      if (rdata_valid) begin
        rd_beats++;
        if (exp_rd.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
        else check("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
      end
      we_prev   = Ram_WE;
      prev_addr = Ram_address;
      prev_data = Ram_data;
    end
    dev_out = dev_rd(Ram_address);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 3000) begin @(negedge CLK); n++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send_cmd(input logic we, input logic [17:0] a, input logic [4:0] len);
    int n;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge CLK); n++; end
    check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [4:0] len, input int gap,
                          input logic [15:0] d0, input logic incr);
    int eff, n, p0, first_wait, cyc;
    time t_prev, t_now;
    logic [15:0] d;
    eff = eff_len(int'(len));
    p0 = we_pulses;
    first_wait = 0;
    t_prev = 0;
    send_cmd(1'b1, a, len);
    for (int i = 0; i < eff; i++) begin
      if (i > 0) repeat (gap) @(negedge CLK);
      d = incr ? d0 + 16'(i) : 16'($urandom);
      wdata = d; wdata_valid = 1'b1;
      n = 0;
      while (!wdata_ready && n < 100) begin @(negedge CLK); n++; end
      check("wready_timeout", 32'(wdata_ready), 32'd1);
      t_now = $time;
      if (i == 0) first_wait = n;
      if (i > 0 && gap == 0) begin
        cyc = int'((t_now - t_prev) / 10);
        check("write_beat_cycles", 32'(cyc), 32'(SETUP + WEC + HOLD + 1));
      end
      t_prev = t_now;
      @(negedge CLK);
      wdata_valid = 1'b0;
      ref_wr[a + 18'(i)] = d;
    end
    wait_idle();
    check("turn_cycles", 32'(first_wait), prev_rd ? 32'd1 : 32'd0);
    check("we_pulse_count", 32'(we_pulses - p0), 32'(eff));
    prev_rd = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a, input logic [4:0] len);
    int eff, r0, o0, p0;
    eff = eff_len(int'(len));
    r0 = rd_beats; o0 = oe_low; p0 = we_pulses;
    for (int i = 0; i < eff; i++) exp_rd.push_back(ref_rd(a + 18'(i)));
    wdata = 16'($urandom); wdata_valid = 1'b1;
    send_cmd(1'b0, a, len);
    wait_idle();
    wdata_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("read_beats", 32'(rd_beats - r0), 32'(eff));
    check("oe_low_cycles", 32'(oe_low - o0), 32'(eff * RDC));
    check("no_write_in_read", 32'(we_pulses - p0), 32'd0);
    check("read_queue_drained", 32'(exp_rd.size()), 32'd0);
    prev_rd = 1'b1;
  endtask

  initial begin
    int n;
    logic [17:0] ra;
    int rl, rg;

    repeat (3) @(negedge CLK);
    check("rst_en", 32'(Ram_EN), 32'd1);
    check("rst_oe", 32'(Ram_OE), 32'd1);
    check("rst_we", 32'(Ram_WE), 32'd1);
    check("rst_addr", 32'(Ram_address), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rvalid", 32'(rdata_valid), 32'd0);
    check("rst_wready", 32'(wdata_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("uart_strobes", {30'd0, rdn, wrn}, 32'd3);
    RST = 1'b1;
    @(negedge CLK);

    do_write(18'h00100, 5'd1, 0, 16'hA5A5, 1'b1);
    check("single_write_mem", 32'(dev_rd(18'h00100)), 32'h0000A5A5);

    do_write(18'h00040, 5'd10, 0, 16'h0001, 1'b1);
    do_read(18'h00040, 5'd10);

    do_read(18'h3FFFE, 5'd4);

    do_write(18'h00300, 5'd3, 5, 16'h1000, 1'b1);

    do_read(18'h00040, 5'd1);
    do_write(18'h00080, 5'd0, 0, 16'hBEEF, 1'b0);
    do_write(18'h00081, 5'd1, 0, 16'hCAFE, 1'b1);
    do_write(18'h3FFF8, 5'd20, 0, 16'h7700, 1'b1);
    do_read(18'h3FFF8, 5'd16);

    // Reset in the middle of a write pulse: the beat is dropped.
    send_cmd(1'b1, 18'h00200, 5'd1);
    wdata = 16'h1234; wdata_valid = 1'b1;
    n = 0;
    while (Ram_WE && n < 50) begin @(posedge CLK); #1; n++; end
    check("we_low_before_reset", 32'(Ram_WE), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("midrst_we", 32'(Ram_WE), 32'd1);
    check("midrst_en", 32'(Ram_EN), 32'd1);
    check("midrst_oe", 32'(Ram_OE), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wready", 32'(wdata_ready), 32'd0);
    wdata_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    prev_rd = 1'b0;
    @(negedge CLK);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("aborted_beat_not_written", 32'(dev_wr.exists(18'h00200)), 32'd0);
    do_read(18'h00200, 5'd1);

    for (int k = 0; k < 30; k++) begin
      ra = 18'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 18'h3FFF0 + 18'($urandom_range(0, 15));
      rl = $urandom_range(0, 20);
      rg = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) do_write(ra, 5'(rl), rg, 16'($urandom), 1'b0);
      else do_read(ra, 5'(rl));
    end

    foreach (ref_wr[k]) check("final_mem", 32'(dev_rd(k)), 32'(ref_wr[k]));
    check("final_read_queue", 32'(exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
